load_register: RTL and testbench

- General-purpose, parameterized, clock-enabled storage register for the processor datapath; default width 16 bits (one machine word).
- Holds its contents until `enable` is asserted, then captures `in` on the next rising clock edge.
- Serves as the building block for general-purpose registers, accumulators and pipeline/holding registers. Adds a synchronous reset to a defined value.

---
 rtl/load_register.sv | 27 ++
 tb/tb_load_register.sv | 124 ++++++++++++
 2 files changed

// File: rtl/load_register.sv
// Clock-enabled storage register with synchronous reset to a parameterized value.
// Used as the basic word register for GPRs, accumulators and pipeline holding stages.
module load_register #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             enable,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] r_data;

   // Reset wins over load; with neither asserted the flops simply hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_data <= RESET_VALUE;
      end else if (enable) begin
         r_data <= in;
      end
   end

   assign out = r_data;

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: default 16-bit instance plus an 8-bit
// instance with a non-zero reset value, both sharing clock, reset and enable.
module tb_load_register;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [15:0] in16;
   logic [15:0] out16;
   logic [7:0]  in8;
   logic [7:0]  out8;

   int n_checks;
   int n_errors;

   load_register u_dut16 (
      .clock  (clock),
      .reset  (reset),
      .in     (in16),
      .enable (enable),
      .out    (out16)
   );

   load_register #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clock  (clock),
      .reset  (reset),
      .in     (in8),
      .enable (enable),
      .out    (out8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end else begin
         $display("check %s got %h ok", tag, got);
      end
   endtask

   // Apply inputs on the falling edge, let one rising edge pass, sample on the next falling edge.
   task automatic cycle(input logic rst, input logic en, input logic [15:0] d16, input logic [7:0] d8);
      reset  = rst;
      enable = en;
      in16   = d16;
      in8    = d8;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      enable   = 1'b1;
      in16     = 16'hFFFF;
      in8      = 8'hFF;
      @(negedge clock);

      // Reset held for two edges while enable and data are active
      cycle(1'b1, 1'b1, 16'hFFFF, 8'hFF);
      check("rst_edge1", out16, 16'h0000);
      check("rst8_edge1", {8'h00, out8}, 16'h00A5);
      cycle(1'b1, 1'b1, 16'hFFFF, 8'hFF);
      check("rst_edge2", out16, 16'h0000);
      check("rst8_edge2", {8'h00, out8}, 16'h00A5);

      // Load with one-cycle latency
      cycle(1'b0, 1'b1, 16'h0003, 8'h3C);
      check("load", out16, 16'h0003);
      check("load8", {8'h00, out8}, 16'h003C);

      // Hold: data changes with enable low never reach the output
      cycle(1'b0, 1'b0, 16'h0007, 8'h11);
      check("hold1", out16, 16'h0003);
      check("hold8", {8'h00, out8}, 16'h003C);
      cycle(1'b0, 1'b0, 16'h0007, 8'h11);
      check("hold2", out16, 16'h0003);
      cycle(1'b0, 1'b1, 16'h0007, 8'h11);
      check("load_after_hold", out16, 16'h0007);
      check("load8_after_hold", {8'h00, out8}, 16'h0011);

      // Output must not follow inputs between edges
      in16   = 16'hDEAD;
      enable = 1'b1;
      reset  = 1'b1;
      #2;
      check("no_comb_path", out16, 16'h0007);

      // Continuous enable tracking
      cycle(1'b0, 1'b1, 16'h1234, 8'h12);
      check("track1", out16, 16'h1234);
      cycle(1'b0, 1'b1, 16'hABCD, 8'hAB);
      check("track2", out16, 16'hABCD);
      check("track8", {8'h00, out8}, 16'h00AB);
      cycle(1'b0, 1'b1, 16'h8000, 8'h80);
      check("track3", out16, 16'h8000);

      // Reset priority mid-operation, then resume loading
      cycle(1'b0, 1'b1, 16'h0007, 8'h07);
      check("preload", out16, 16'h0007);
      cycle(1'b1, 1'b1, 16'h5555, 8'h55);
      check("rst_priority", out16, 16'h0000);
      check("rst8_priority", {8'h00, out8}, 16'h00A5);
      cycle(1'b0, 1'b1, 16'h5555, 8'h55);
      check("resume", out16, 16'h5555);
      check("resume8", {8'h00, out8}, 16'h0055);

      // Stability across a full idle cycle
      cycle(1'b0, 1'b0, 16'h0000, 8'h00);
      check("stable", out16, 16'h5555);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
